fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side drain engine for the 64-bit, 1024-deep DDC sample FIFO, running in the FIFO read-clock domain.
- Waits until a full burst of samples is buffered, then reads exactly BURST_LEN words and frames them as one packet: one header word followed by BURST_LEN data words.
- Output is a valid/ready stream toward the SRIO packet builder, with full backpressure support.
- Handles the FIFO's 1-cycle read latency internally.

Parameters:
- DATA_W, 64, FIFO/stream data width.
- CNT_W, 10, width of the FIFO rd_data_count.
- BURST_LEN, 16, data words per packet; legal range 1..1023.
- HDR_TAG, 8'hC0, constant in header bits [63:56].

Ports:
- clk  in  1  read-side clock; FIFO rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new packets to start; sampled only in IDLE.
- fifo_dout  in  DATA_W  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data_count  in  CNT_W  FIFO read occupancy.
- fifo_rd_en  out  1  FIFO read strobe.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from sink.
- m_sop  out  1  high on the header beat.
- m_eop  out  1  high on the last data beat.
- busy  out  1  high whenever state is not IDLE.
- seq_num  out  16  sequence number of the next packet.
- err_underflow  out  1  sticky flag; FIFO went empty during a packet.

Behaviour:
- Reset (async, rst_n=0): state IDLE; fifo_rd_en=0, m_valid=0, m_sop=0, m_eop=0, m_data=0, busy=0, seq_num=0, err_underflow=0; output buffer and read counters cleared. Reset mid-packet abandons the packet; no partial eop is emitted.
- Handshake: a beat transfers when m_valid && m_ready. Once m_valid rises, m_data/m_sop/m_eop are held stable until the transfer.
- Output buffer: 2-entry skid buffer.
  - fifo_rd_en = (state==DATA) && !fifo_empty && (words_issued < BURST_LEN) && (buffer occupancy + reads in flight < 2).
  - A read issued in cycle N lands in the buffer at the cycle N+1 edge.
  - Buffer never overflows; a sink that holds ready high sustains 1 word/cycle.
- IDLE:
  - Go to HDR when enable && fifo_rd_data_count >= BURST_LEN.
  - fifo_rd_en stays 0.
- HDR:
  - m_valid=1, m_sop=1, m_data = {HDR_TAG, 8'h00, seq_num, BURST_LEN[15:0], 16'h0000}.
  - On transfer, go to DATA.
  - The first FIFO read may be issued in the same cycle as the header transfer.
- DATA:
  - Words are forwarded in FIFO order.
  - words_issued counts reads; words_sent counts data transfers.
  - m_eop=1 on the beat where words_sent == BURST_LEN-1.
  - On the eop transfer, go to IDLE and seq_num increments, wrapping 16'hFFFF -> 0.
  - Next packet header earliest: 1 cycle after the eop transfer (IDLE evaluation cycle).
- enable deasserted mid-packet: the current packet completes normally; no new packet starts.
- fifo_empty during DATA with words_issued < BURST_LEN:
  - No read is issued; err_underflow is set (sticky until reset).
  - The engine stalls and resumes when data reappears.
  - Packet length is never truncated.
- Minimum packet time: BURST_LEN+1 cycles with m_ready held high.

Test Plan:
- Basic packet: BURST_LEN=16, FIFO preloaded with 0..15, enable=1, m_ready=1.
  - Header beat with sop=1 and m_data=64'hC000_0000_0010_0000.
  - Then 16 consecutive data beats 0..15, eop on value 15.
  - Total 17 cycles; seq_num 0 -> 1.
- Threshold: fill FIFO to 15 words.
  - No fifo_rd_en and busy=0.
  - Write a 16th word: header appears within 2 cycles.
- Backpressure: m_ready toggled 1,0,0,1,… over a packet of 0..15.
  - Stream equals 0..15 exactly, no duplication or loss.
  - m_data stable while stalled; fifo_rd_en never leaves the buffer holding more than 2 words.
- Underflow: rd_data_count forced to 16 while only 8 words are present.
  - 8 data beats, then a stall, and err_underflow=1.
  - Writing 8 more words completes the packet with eop on the 16th.
- Enable/seq wrap: preset seq via 65536 packets (or force seq_num=16'hFFFF), run 2 packets.
  - Headers carry FFFF then 0000.
  - enable dropped during the second packet: the packet completes and no third header follows.
- Reset mid-packet: rst_n low after 5 data beats.
  - All outputs 0 immediately (asynchronous).
  - After release with 16+ words buffered, the next header carries seq 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains one BURST_LEN burst from the sample FIFO per packet: header beat, then data beats in FIFO order.
// Data beat N+1 cycles after its read (FIFO output bypass); m_ready low stalls in place, 2-entry skid absorbs in-flight reads.
module fifo_burst_reader #(
   parameter int         DATA_W    = 64,
   parameter int         CNT_W     = 10,
   parameter int         BURST_LEN = 16,
   parameter logic [7:0] HDR_TAG   = 8'hC0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   input  logic [CNT_W-1:0]  fifo_rd_data_count,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sop,
   output logic              m_eop,
   output logic              busy,
   output logic [15:0]       seq_num,
   output logic              err_underflow
);

   localparam int               IW      = $clog2(BURST_LEN + 1);
   localparam logic [IW-1:0]    BL_W    = IW'(BURST_LEN);
   localparam logic [IW-1:0]    BL_LAST = IW'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] BL_C    = CNT_W'(BURST_LEN);
   localparam logic [15:0]      BL_16   = 16'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t            state;
   logic [DATA_W-1:0] skid0, skid1;
   logic [1:0]        skid_cnt;
   logic              in_flight;
   logic [IW-1:0]     words_issued, words_sent;
   logic              have_word, hdr_xfer, pop_dat, last_beat;
   logic [2:0]        pending;

   // The word on fifo_dout counts as present, so a fresh read can be sent straight out.
   assign have_word = (skid_cnt != 2'd0) || in_flight;
   assign hdr_xfer  = (state == HDR) && m_ready;
   assign pop_dat   = (state == DATA) && have_word && m_ready;
   assign last_beat = (words_sent == BL_LAST);
   assign pending   = 3'(skid_cnt) + 3'(in_flight) - 3'(pop_dat);

   assign fifo_rd_en = (hdr_xfer || state == DATA) && !fifo_empty &&
                       (words_issued < BL_W) && (pending < 3'd2);
   assign m_valid = (state == HDR) || (state == DATA && have_word);
   assign m_sop   = (state == HDR);
   assign m_eop   = (state == DATA) && have_word && last_beat;
   assign busy    = (state != IDLE);

   always_comb begin
      m_data = '0;
      if (state == HDR)
         m_data = DATA_W'({HDR_TAG, 8'h00, seq_num, BL_16, 16'h0000});
      else if (state == DATA && have_word)
         m_data = (skid_cnt != 2'd0) ? skid0 : fifo_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         skid0         <= '0;
         skid1         <= '0;
         skid_cnt      <= '0;
         in_flight     <= 1'b0;
         words_issued  <= '0;
         words_sent    <= '0;
         seq_num       <= '0;
         err_underflow <= 1'b0;
      end else begin
         in_flight <= fifo_rd_en;
         skid_cnt  <= pending[1:0];
         if (fifo_rd_en)
            words_issued <= words_issued + IW'(1);

         if (pop_dat) begin
            if (skid_cnt == 2'd2)
               skid0 <= skid1;
            else if (skid_cnt == 2'd1 && in_flight)
               skid0 <= fifo_dout;
            if (skid_cnt == 2'd2 && in_flight)
               skid1 <= fifo_dout;
         end else if (in_flight) begin
            if (skid_cnt == 2'd0)
               skid0 <= fifo_dout;
            else
               skid1 <= fifo_dout;
         end

         if (state == DATA && fifo_empty && words_issued < BL_W)
            err_underflow <= 1'b1;

         case (state)
            IDLE: if (enable && fifo_rd_data_count >= BL_C) state <= HDR;
            HDR:  if (m_ready) state <= DATA;
            DATA: begin
               if (pop_dat) begin
                  words_sent <= words_sent + IW'(1);
                  if (last_beat) begin
                     state        <= IDLE;
                     seq_num      <= seq_num + 16'd1;
                     words_sent   <= '0;
                     words_issued <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO, packet-level reference stream, per-cycle beat compare.
module tb_fifo_burst_reader;
   localparam int BL = 16;

   logic        clk = 1'b0;
   logic        rst_n, enable, m_ready;
   logic        fifo_empty, fifo_rd_en, m_valid, m_sop, m_eop, busy, err_underflow;
   logic [63:0] fifo_dout = '0;
   logic [63:0] m_data;
   logic [9:0]  fifo_rd_data_count;
   logic [15:0] seq_num;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_W(64), .CNT_W(10), .BURST_LEN(BL), .HDR_TAG(8'hC0)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_data_count(fifo_rd_data_count),
      .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_sop(m_sop), .m_eop(m_eop), .busy(busy), .seq_num(seq_num), .err_underflow(err_underflow)
   );

   // FIFO stand-in: 1-cycle read latency, writes visible in the flags after the next edge
   logic [63:0] fq[$];
   int          fq_size = 0;
   int          cnt_force = -1;
   assign fifo_empty         = (fq_size == 0);
   assign fifo_rd_data_count = (cnt_force >= 0) ? 10'(cnt_force) : 10'(fq_size);

   always @(posedge clk) begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      fq_size <= fq.size();
   end

   // reference model: every word written must leave in order, framed as header + BL words
   logic [63:0] ref_q[$];
   logic [15:0] exp_seq;
   int          checks = 0, failures = 0;
   int          cyc = 0, beat_idx = 0, pkts = 0, hdrs = 0, outstanding = 0;
   int          hdr_cyc = 0, eop_cyc = 0;
   logic [63:0] last_hdr = '0, last_eop_dat = '0, prev_data = '0;
   logic [1:0]  prev_flags = '0;
   logic        prev_stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_cycle();
      logic [63:0] exp_d;
      logic        exp_eop;
      cyc++;
      if (rst_n) begin
         chk("rd_en_while_idle", 64'(fifo_rd_en & ~busy), 64'd0);
         if (prev_stall) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", m_data, prev_data);
            chk("hold_flags", 64'({m_sop, m_eop}), 64'(prev_flags));
         end
         outstanding += int'(fifo_rd_en);
         if (m_valid && m_ready && !m_sop) outstanding--;
         chk("buffer_le_2", 64'(outstanding > 2), 64'd0);
         if (m_valid && m_ready) begin
            if (beat_idx == 0) begin
               exp_d   = {8'hC0, 8'h00, exp_seq, 16'(BL), 16'h0000};
               exp_eop = 1'b0;
            end else begin
               exp_d   = (ref_q.size() > 0) ? ref_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
               exp_eop = (beat_idx == BL);
            end
            chk("beat_data", m_data, exp_d);
            chk("beat_flags", 64'({m_sop, m_eop}), 64'({beat_idx == 0, exp_eop}));
            if (beat_idx == 0) begin
               hdr_cyc  = cyc;
               last_hdr = m_data;
               hdrs++;
            end
            if (beat_idx == BL) begin
               eop_cyc      = cyc;
               last_eop_dat = m_data;
               beat_idx     = 0;
               exp_seq      = exp_seq + 16'd1;
               pkts++;
            end else begin
               beat_idx++;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_flags = {m_sop, m_eop};
      end
   endtask

   // called at a falling edge with this cycle's inputs already driven
   task automatic tick();
      #1;
      mon_cycle();
      @(negedge clk);
   endtask

   task automatic push(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(64'(base + i));
         ref_q.push_back(64'(base + i));
      end
   endtask

   task automatic wait_pkts(input int target, input int budget, input bit bp);
      int n = 0;
      while (pkts < target && n < budget) begin
         if (bp) m_ready = (n % 4 == 0) || (n % 4 == 3);
         tick();
         n++;
      end
      m_ready = 1'b1;
      chk("packets_done", 64'(pkts), 64'(target));
   endtask

   task automatic wait_beat(input int idx, input int budget);
      int n = 0;
      while (beat_idx < idx && n < budget) begin
         tick();
         n++;
      end
      chk("beat_reached", 64'(beat_idx), 64'(idx));
   endtask

   initial begin
      int cyc_push, h0;
      rst_n   = 1'b0;
      enable  = 1'b0;
      m_ready = 1'b1;
      exp_seq = 16'd0;
      @(negedge clk);
      #1;
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data", m_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_seq", 64'(seq_num), 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic packet, 0..15
      push(0, BL);
      tick(); tick(); tick();
      chk("disabled_busy", 64'(busy), 64'd0);
      enable = 1'b1;
      wait_pkts(1, 60, 1'b0);
      chk("basic_hdr", last_hdr, 64'hC000_0000_0010_0000);
      chk("basic_cycles", 64'(eop_cyc - hdr_cyc + 1), 64'd17);
      chk("basic_last", last_eop_dat, 64'd15);
      chk("basic_seq", 64'(seq_num), 64'd1);
      tick();
      chk("basic_idle", 64'(busy), 64'd0);
      chk("basic_no_err", 64'(err_underflow), 64'd0);

      // threshold: 15 words must not start a packet
      push(100, BL - 1);
      for (int i = 0; i < 6; i++) tick();
      chk("thr_busy", 64'(busy), 64'd0);
      chk("thr_rd_en", 64'(fifo_rd_en), 64'd0);
      push(100 + BL - 1, 1);
      cyc_push = cyc;
      wait_pkts(2, 60, 1'b0);
      chk("thr_hdr_latency", 64'(hdr_cyc - cyc_push), 64'd3);

      // backpressure with ready 1,0,0,1,...
      push(200, BL);
      wait_pkts(3, 200, 1'b1);
      chk("bp_last", last_eop_dat, 64'd215);
      chk("bp_ref_drained", 64'(ref_q.size()), 64'd0);

      // underflow: count claims a burst while only half is present
      push(300, 8);
      tick();
      cnt_force = BL;
      for (int i = 0; i < 40; i++) tick();
      cnt_force = -1;
      chk("uf_beats", 64'(beat_idx), 64'd9);
      chk("uf_err", 64'(err_underflow), 64'd1);
      chk("uf_busy", 64'(busy), 64'd1);
      chk("uf_stalled", 64'(m_valid), 64'd0);
      push(308, 8);
      wait_pkts(4, 60, 1'b0);
      chk("uf_last", last_eop_dat, 64'd315);
      chk("uf_err_sticky", 64'(err_underflow), 64'd1);

      // sequence wrap and enable drop
      tick();
      force dut.seq_num = 16'hFFFF;
      tick();
      release dut.seq_num;
      exp_seq = 16'hFFFF;
      tick();
      chk("wrap_preset", 64'(seq_num), 64'hFFFF);
      push(400, 2 * BL);
      wait_pkts(5, 60, 1'b0);
      chk("wrap_hdr_ffff", last_hdr, 64'hC000_FFFF_0010_0000);
      chk("wrap_seq0", 64'(seq_num), 64'd0);
      wait_beat(3, 20);
      enable = 1'b0;
      wait_pkts(6, 60, 1'b0);
      chk("wrap_hdr_0000", last_hdr, 64'hC000_0000_0010_0000);
      chk("wrap_seq1", 64'(seq_num), 64'd1);
      push(500, BL);
      h0 = hdrs;
      for (int i = 0; i < 30; i++) tick();
      chk("en_off_no_hdr", 64'(hdrs), 64'(h0));
      chk("en_off_busy", 64'(busy), 64'd0);

      // asynchronous reset in the middle of a packet
      enable = 1'b1;
      wait_beat(6, 40);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(m_valid), 64'd0);
      chk("arst_sop_eop", 64'({m_sop, m_eop}), 64'd0);
      chk("arst_data", m_data, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_seq", 64'(seq_num), 64'd0);
      chk("arst_err", 64'(err_underflow), 64'd0);
      chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
      beat_idx    = 0;
      exp_seq     = 16'd0;
      outstanding = 0;
      prev_stall  = 1'b0;
      @(negedge clk);
      tick();
      ref_q = fq;
      push(600, BL);
      rst_n = 1'b1;
      wait_pkts(7, 60, 1'b0);
      chk("post_rst_hdr", last_hdr, 64'hC000_0000_0010_0000);
      chk("post_rst_seq", 64'(seq_num), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
